multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl -- Moore control FSM for a multicycle MIPS-subset datapath.
//
// Supported instructions: lw, sw, R-type (addu/subu/and/or/slt), beq, j,
// addiu, ori. One instruction is sequenced per pass through the state graph,
// starting and ending in FETCH.
//
// Memory handshake: mem_req is held high for the whole access. The access
// completes in the cycle where mem_req and mem_ready are both high. mem_we
// qualifies mem_req and has no meaning on its own.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   opcode     in   IR[31:26], held stable from DECODE to the end of the instr
//   funct      in   IR[5:0]
//   zero       in   ALU zero flag (used in BRANCH)
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access request
//   mem_we     out  write strobe (only meaningful with mem_req)
//   iord       out  address select: 0 PC, 1 ALUOut
//   ir_we      out  instruction register load
//   pc_we      out  PC load
//   pc_src     out  PC source: 0 ALU, 1 ALUOut, 2 jump target
//   alu_src_a  out  ALU A: 0 PC, 1 reg A
//   alu_src_b  out  ALU B: 0 reg B, 1 const 4, 2 ext imm, 3 sext imm<<2
//   ext_zero   out  immediate extension: 1 zero-extend
//   alu_ctrl   out  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 slt
//   reg_we     out  register file write
//   reg_dst    out  write register select: 0 rt, 1 rd
//   mem_to_reg out  write data select: 1 MDR
//   state      out  current state code (debug / checker visibility)
//   illegal    out  sticky illegal-instruction flag
//
// Configuration macro: MC_ILLEGAL_TRAP_EN
//   defined   -> illegal opcode/funct enters TRAP (locks up until reset) and
//                sets illegal
//   undefined -> illegal instruction behaves as a NOP, illegal is tied low
// ---------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_ctrl,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILL_DEST = S_TRAP;
`else
    localparam state_t ILL_DEST = S_FETCH;   // illegal instruction = NOP
`endif

    state_t cur, nxt;

    // R-type function decode, shared by EXEC output and next-state logic
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'h21:   funct_alu = ALU_ADD;
            6'h23:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     nxt = S_MEMADR;
                    OP_RTYPE:         nxt = S_EXEC;
                    OP_BEQ:           nxt = S_BRANCH;
                    OP_J:             nxt = S_JUMP;
                    OP_ADDIU, OP_ORI: nxt = S_IEXEC;
                    default:          nxt = ILL_DEST;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = funct_ok ? S_RWB : ILL_DEST;
            S_RWB:    nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_IEXEC:  nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    // Output logic. Strobes are computed here ungated and masked by rst
    // below so that nothing fires while reset is held (FETCH would
    // otherwise request memory during reset).
    logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;

    always_comb begin
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        iord       = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        ext_zero   = 1'b0;
        alu_ctrl   = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (cur)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; both
                // registers load only on the completing cycle.
                mem_req_c = 1'b1;
                ir_we_c   = mem_ready;
                pc_we_c   = mem_ready;
                alu_src_b = 2'd1;
            end
            S_DECODE: alu_src_b = 2'd3;          // speculative branch target
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                reg_we_c   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = funct_alu;
            end
            S_RWB: begin
                reg_we_c = 1'b1;
                reg_dst  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_we_c   = zero;
                pc_src    = 2'd1;
            end
            S_JUMP: begin
                pc_we_c = 1'b1;
                pc_src  = 2'd2;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_zero  = (opcode == OP_ORI);
                alu_ctrl  = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IWB:   reg_we_c = 1'b1;
            default: ;                           // TRAP: everything idle
        endcase
    end

    assign mem_req = mem_req_c & rst;
    assign mem_we  = mem_we_c  & rst;
    assign ir_we   = ir_we_c   & rst;
    assign pc_we   = pc_we_c   & rst;
    assign reg_we  = reg_we_c  & rst;
    assign state   = cur;

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Set on the transition into TRAP so it is visible together with state=12
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               illegal_q <= 1'b0;
        else if (nxt == S_TRAP) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl -- self-checking bench for multicycle_ctrl.
//
// Each driven cycle pushes the expected output vector (value + care mask)
// onto exp_q; a negedge monitor pops and compares it against the DUT.
// Output vector layout (MSB..LSB):
//   state[21:18] illegal[17] alu_ctrl[16:14] alu_src_b[13:12] pc_src[11:10]
//   alu_src_a[9] ext_zero[8] mem_to_reg[7] reg_dst[6] reg_we[5] pc_we[4]
//   ir_we[3] iord[2] mem_we[1] mem_req[0]
// Build with +define+MC_ILLEGAL_TRAP_EN to check the trap variant.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, ext_zero;
    logic [2:0] alu_ctrl;
    logic       reg_we, reg_dst, mem_to_reg;
    logic [3:0] state;
    logic       illegal;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .alu_ctrl(alu_ctrl), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [43:0] exp_q[$];          // {mask[21:0], value[21:0]}
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    localparam int MR = 0, MW = 1, IO = 2, IRW = 3, PW = 4, RW = 5, RD = 6,
                   MT = 7, EZ = 8, ASA = 9, IL = 17;
    localparam logic [21:0] M_BASE  = 22'h3E003B; // state, illegal, strobes
    localparam logic [21:0] M_IO    = 22'h000004;
    localparam logic [21:0] M_RD    = 22'h000040;
    localparam logic [21:0] M_MT    = 22'h000080;
    localparam logic [21:0] M_EZ    = 22'h000100;
    localparam logic [21:0] M_ASA   = 22'h000200;
    localparam logic [21:0] M_PS    = 22'h000C00;
    localparam logic [21:0] M_ASB   = 22'h003000;
    localparam logic [21:0] M_AC    = 22'h01C000;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for one cycle in state s. s=13 means "reset held".
    // a: mem_ready in FETCH, zero in BRANCH, is-ori in IEXEC.
    // ac: ALU op in EXEC (7 = not checked).
    function automatic logic [43:0] exp_for(input int s, input logic a,
                                            input logic [2:0] ac);
        logic [21:0] e, m;
        e = '0;
        m = M_BASE;
        if (s != 13) e[21:18] = 4'(s);
        case (s)
            0: begin
                e[MR] = 1'b1; e[IRW] = a; e[PW] = a; e[13:12] = 2'd1;
                m |= M_IO | M_ASA | M_PS | M_ASB | M_AC;
            end
            1: begin e[13:12] = 2'd3; m |= M_ASA | M_ASB | M_AC; end
            3: begin e[MR] = 1'b1; e[IO] = 1'b1; m |= M_IO; end
            4: begin e[RW] = 1'b1; e[MT] = 1'b1; m |= M_RD | M_MT; end
            5: begin e[MR] = 1'b1; e[MW] = 1'b1; e[IO] = 1'b1; m |= M_IO; end
            6: begin
                e[ASA] = 1'b1; m |= M_ASA | M_ASB;
                if (ac != 3'd7) begin e[16:14] = ac; m |= M_AC; end
            end
            7: begin e[RW] = 1'b1; e[RD] = 1'b1; m |= M_RD; end
            8: begin
                e[16:14] = 3'd1; e[PW] = a; m |= M_AC;
                if (a) begin e[11:10] = 2'd1; m |= M_PS; end
            end
            9: begin e[PW] = 1'b1; e[11:10] = 2'd2; m |= M_PS; end
            10: begin
                e[EZ] = a; e[16:14] = a ? 3'd3 : 3'd0; m |= M_EZ | M_AC;
            end
            11: begin e[RW] = 1'b1; m |= M_RD; end
            12: e[IL] = 1'b1;
            default: ;
        endcase
        return {m, e};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [43:0] x;
            logic [21:0] obs;
            string       t;
            x   = exp_q.pop_front();
            t   = tag_q.pop_front();
            obs = {state, illegal, alu_ctrl, alu_src_b, pc_src, alu_src_a,
                   ext_zero, mem_to_reg, reg_dst, reg_we, pc_we, ir_we, iord,
                   mem_we, mem_req};
            check_eq(t, 32'(obs & x[43:22]), 32'(x[21:0] & x[43:22]));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1: drive one cycle and queue its expectation.
    task automatic step(input string tag, input int s, input logic a,
                        input logic [2:0] ac, input logic rdy, input logic zr);
        mem_ready = rdy;
        zero      = zr;
        exp_q.push_back(exp_for(s, a, ac));
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input string tag, input int waits);
        for (int i = 0; i < waits; i++) step({tag, "_fwait"}, 0, 1'b0, 3'd0, 1'b0, rnd());
        step({tag, "_fetch"}, 0, 1'b1, 3'd0, 1'b1, rnd());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step("rst_hold0", 13, 1'b0, 3'd0, rnd(), rnd());
        step("rst_hold1", 13, 1'b0, 3'd0, rnd(), rnd());
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] rfun [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [2:0] rop  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    initial begin
        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // addu, no waits: 0,1,6,7 then back to FETCH
        opcode = 6'h00; funct = 6'h21;
        fetch("addu", 0);
        step("addu_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("addu_exec", 6, 1'b0, 3'd0, rnd(), rnd());
        step("addu_rwb", 7, 1'b0, 3'd0, rnd(), rnd());

        // all R-type functs with random fetch waits
        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00; funct = rfun[i];
            fetch("rtype", $urandom_range(0, 2));
            step("rtype_dec", 1, 1'b0, 3'd0, rnd(), rnd());
            step("rtype_exec", 6, 1'b0, rop[i], rnd(), rnd());
            step("rtype_rwb", 7, 1'b0, 3'd0, rnd(), rnd());
        end

        // lw with two wait cycles in MEMRD: 7 cycles total
        opcode = 6'h23; funct = 6'($urandom_range(0, 63));
        fetch("lw", 0);
        step("lw_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("lw_adr", 2, 1'b0, 3'd0, rnd(), rnd());
        step("lw_rd_w0", 3, 1'b0, 3'd0, 1'b0, rnd());
        step("lw_rd_w1", 3, 1'b0, 3'd0, 1'b0, rnd());
        step("lw_rd", 3, 1'b0, 3'd0, 1'b1, rnd());
        step("lw_wb", 4, 1'b0, 3'd0, rnd(), rnd());

        // sw with one wait
        opcode = 6'h2B;
        fetch("sw", 1);
        step("sw_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("sw_adr", 2, 1'b0, 3'd0, rnd(), rnd());
        step("sw_wr_w", 5, 1'b0, 3'd0, 1'b0, rnd());
        step("sw_wr", 5, 1'b0, 3'd0, 1'b1, rnd());

        // beq taken then not taken
        opcode = 6'h04;
        fetch("beq_t", 0);
        step("beq_t_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("beq_t_br", 8, 1'b1, 3'd0, rnd(), 1'b1);
        fetch("beq_n", 0);
        step("beq_n_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("beq_n_br", 8, 1'b0, 3'd0, rnd(), 1'b0);

        // j
        opcode = 6'h02;
        fetch("j", 0);
        step("j_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("j_jump", 9, 1'b0, 3'd0, rnd(), rnd());

        // addiu then ori
        opcode = 6'h09;
        fetch("addiu", 0);
        step("addiu_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("addiu_ex", 10, 1'b0, 3'd0, rnd(), rnd());
        step("addiu_wb", 11, 1'b0, 3'd0, rnd(), rnd());
        opcode = 6'h0D;
        fetch("ori", 0);
        step("ori_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("ori_ex", 10, 1'b1, 3'd0, rnd(), rnd());
        step("ori_wb", 11, 1'b0, 3'd0, rnd(), rnd());

        // reset asserted mid-MEMWR
        opcode = 6'h2B;
        fetch("swr", 0);
        step("swr_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("swr_adr", 2, 1'b0, 3'd0, rnd(), rnd());
        step("swr_wr_w", 5, 1'b0, 3'd0, 1'b0, rnd());
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_state", 32'(state), 32'd0);
        check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
        check_eq("midrst_mem_req", 32'(mem_req), 32'd0);
        check_eq("midrst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        do_reset();
        fetch("post_rst", 0);                    // mem_req=1, iord=0 right away
        step("post_rst_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("post_rst_adr", 2, 1'b0, 3'd0, rnd(), rnd());
        step("post_rst_wr", 5, 1'b0, 3'd0, 1'b1, rnd());

        // illegal funct
        opcode = 6'h00; funct = 6'h3F;
        fetch("badfn", 0);
        step("badfn_dec", 1, 1'b0, 3'd0, rnd(), rnd());
        step("badfn_exec", 6, 1'b0, 3'd7, rnd(), rnd());
`ifdef MC_ILLEGAL_TRAP_EN
        step("badfn_trap0", 12, 1'b0, 3'd0, rnd(), rnd());
        step("badfn_trap1", 12, 1'b0, 3'd0, rnd(), rnd());
        do_reset();
`else
        step("badfn_ret", 0, 1'b0, 3'd0, 1'b0, rnd());
`endif

        // illegal opcode
        opcode = 6'h3F; funct = 6'h21;
        fetch("badop", 0);
        step("badop_dec", 1, 1'b0, 3'd0, rnd(), rnd());
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step("badop_trap", 12, 1'b0, 3'd0, rnd(), rnd());
`else
        step("badop_ret", 0, 1'b0, 3'd0, 1'b0, rnd());
        step("badop_ret2", 0, 1'b0, 3'd0, 1'b0, rnd());
`endif

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
